// File: rtl/lfsr8_period_meter.sv
// Measures the recurrence period of an 8-bit LFSR word stream, the total of 1 bits over
// that period, and flags an all-zero reference word. One measurement per start.
module lfsr8_period_meter #(
  parameter int MAX_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        valid_in,
  input  logic [1:8]  q_in,
  output logic        busy,
  output logic        done,
  output logic [8:0]  period,
  output logic [11:0] ones_sum,
  output logic        lockup,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t      state_q;
  logic [1:8]  ref_q;
  logic [8:0]  count_q;
  logic [11:0] acc_q;

  function automatic logic [3:0] popcnt(input logic [1:8] v);
    logic [3:0] n;
    n = '0;
    for (int i = 1; i <= 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  logic [11:0] acc_next;
  assign acc_next = acc_q + {8'd0, popcnt(q_in)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      period   <= '0;
      ones_sum <= '0;
      lockup   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // The sample arriving alongside start is never used as the reference.
          if (start) begin
            state_q  <= ARM;
            busy     <= 1'b1;
            done     <= 1'b0;
            period   <= '0;
            ones_sum <= '0;
            lockup   <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        ARM: begin
          if (valid_in) begin
            ref_q <= q_in;
            if (q_in == 8'h00) begin
              state_q  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              lockup   <= 1'b1;
              period   <= 9'd1;
              ones_sum <= '0;
            end else begin
              state_q <= MEASURE;
              count_q <= 9'd1;
              acc_q   <= {8'd0, popcnt(q_in)};
            end
          end
        end
        MEASURE: begin
          if (valid_in) begin
            if (q_in == ref_q) begin
              state_q  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              period   <= count_q;
              ones_sum <= acc_q;
            end else if (count_q >= 9'(MAX_SAMPLES)) begin
              // The abandoning sample is still counted into the ones total.
              state_q  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              timeout  <= 1'b1;
              period   <= '0;
              ones_sum <= acc_next;
            end else begin
              count_q <= count_q + 9'd1;
              acc_q   <= acc_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr8_period_meter.sv
// Randomised bench for lfsr8_period_meter against a recurrence-search reference model.
module tb_lfsr8_period_meter;
  localparam int MAX = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  q_in = 8'h00;
  logic        busy, done, lockup, timeout;
  logic [8:0]  period;
  logic [11:0] ones_sum;

  lfsr8_period_meter #(.MAX_SAMPLES(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .q_in(q_in),
    .busy(busy), .done(done), .period(period), .ones_sum(ones_sum),
    .lockup(lockup), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] stim_q[$];
  int exp_period, exp_ones, exp_used;
  bit exp_lock, exp_to;
  int consumed, cycles;
  bit busy_after_start, got_done;
  logic [7:0] junk_val;

  // Reference: scan the valid-sample list for the first recurrence of word 0.
  function automatic void model();
    int sum;
    exp_lock = 0; exp_to = 0; exp_used = -1; exp_period = 0; exp_ones = 0;
    if (stim_q[0] == 8'h00) begin
      exp_lock = 1; exp_period = 1; exp_ones = 0; exp_used = 1;
      return;
    end
    sum = $countones(stim_q[0]);
    for (int i = 1; i < stim_q.size(); i++) begin
      if (stim_q[i] == stim_q[0]) begin
        exp_period = i; exp_ones = sum; exp_used = i + 1;
        return;
      end
      sum += $countones(stim_q[i]);
      if (i == MAX) begin
        exp_to = 1; exp_period = 0; exp_ones = sum; exp_used = i + 1;
        return;
      end
    end
  endfunction

  function automatic void make_lfsr(input int n);
    logic [7:0] s;
    s = 8'h01;
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(s);
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endfunction

  // gap_mode 0: always valid, 1: alternate, 2: random gaps
  task automatic run_meter(input int gap_mode, input bit junk_on_start, input bit poke_start);
    int idx;
    int cyc;
    bit v;
    idx = 0; cyc = 0;
    start = 1'b1; valid_in = junk_on_start; q_in = junk_val;
    @(posedge clk); #1;
    start = 1'b0;
    busy_after_start = busy;
    while (!done && cyc < 3000) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (v && idx < stim_q.size()) begin
        valid_in = 1'b1; q_in = stim_q[idx]; idx++;
      end else begin
        valid_in = 1'b0; q_in = 8'($urandom);
      end
      start = (poke_start && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0; start = 1'b0;
    consumed = idx; cycles = cyc; got_done = done;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, period, ones_sum, lockup, timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {busy, done, period, ones_sum, lockup, timeout});
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; q_in = 8'($urandom);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores_samples: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_max_lfsr();
    make_lfsr(300); model(); junk_val = 8'h00;
    run_meter(0, 1'b0, 1'b0);
    n_checks++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL lfsr_busy: got %b required 1", busy_after_start); end
    n_checks++; if (period !== 9'd255) begin n_fail++; $display("FAIL lfsr_period: got %0d required 255", period); end
    n_checks++; if (ones_sum !== 12'(exp_ones)) begin n_fail++; $display("FAIL lfsr_ones: got %0d required %0d", ones_sum, exp_ones); end
    n_checks++; if (lockup !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lfsr_flags: got lockup=%b timeout=%b busy=%b required 0 0 0", lockup, timeout, busy); end
    n_checks++; if (cycles != exp_used) begin n_fail++; $display("FAIL lfsr_latency: got %0d required %0d", cycles, exp_used); end
  endtask

  task automatic test_constant();
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(8'h5A);
    model(); junk_val = 8'h00;
    // A zero word alongside start would signal lock-up if wrongly taken as reference.
    run_meter(0, 1'b1, 1'b0);
    n_checks++; if (period !== 9'(exp_period) || ones_sum !== 12'd4) begin n_fail++; $display("FAIL const_result: got period=%0d ones=%0d required %0d 4", period, ones_sum, exp_period); end
    n_checks++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL const_start_sample: got lockup=%b required 0", lockup); end
    n_checks++; if (cycles != 2) begin n_fail++; $display("FAIL const_latency: got %0d required 2", cycles); end
  endtask

  task automatic test_lockup();
    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h33); stim_q.push_back(8'h00);
    model(); junk_val = 8'h77;
    run_meter(0, 1'b1, 1'b0);
    n_checks++; if (lockup !== 1'b1 || period !== 9'd1 || ones_sum !== 12'd0) begin n_fail++; $display("FAIL lockup_result: got lockup=%b period=%0d ones=%0d required 1 1 0", lockup, period, ones_sum); end
    n_checks++; if (cycles != 1 || done !== 1'b1) begin n_fail++; $display("FAIL lockup_latency: got %0d required 1", cycles); end
  endtask

  task automatic test_timeout();
    stim_q.delete();
    stim_q.push_back(8'h01);
    for (int i = 0; i < 300; i++) stim_q.push_back(8'h02);
    model(); junk_val = 8'h01;
    run_meter(0, 1'b0, 1'b0);
    n_checks++; if (timeout !== 1'b1 || period !== 9'd0) begin n_fail++; $display("FAIL timeout_flag: got timeout=%b period=%0d required 1 0", timeout, period); end
    n_checks++; if (ones_sum !== 12'(exp_ones) || ones_sum !== 12'd257) begin n_fail++; $display("FAIL timeout_ones: got %0d required 257", ones_sum); end
    n_checks++; if (consumed != exp_used) begin n_fail++; $display("FAIL timeout_samples: got %0d required %0d", consumed, exp_used); end
  endtask

  task automatic test_gapped();
    make_lfsr(300); model(); junk_val = 8'h01;
    run_meter(1, 1'b1, 1'b0);
    n_checks++; if (period !== 9'(exp_period) || ones_sum !== 12'd1024) begin n_fail++; $display("FAIL gapped_result: got period=%0d ones=%0d required %0d 1024", period, ones_sum, exp_period); end
    n_checks++; if (cycles != 2 * exp_used - 1) begin n_fail++; $display("FAIL gapped_latency: got %0d required %0d", cycles, 2 * exp_used - 1); end
  endtask

  task automatic test_reset_mid();
    make_lfsr(150);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      valid_in = 1'b1; q_in = stim_q[i];
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    rst = 1'b1; #2;
    n_checks++;
    if ({busy, done, period, ones_sum, lockup, timeout} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 0", {busy, done, period, ones_sum, lockup, timeout});
    end
    @(posedge clk); #1; rst = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back(8'hFF);
    model(); junk_val = 8'h00;
    run_meter(0, 1'b0, 1'b0);
    n_checks++; if (period !== 9'd1 || ones_sum !== 12'(exp_ones) || exp_ones != 8) begin n_fail++; $display("FAIL midreset_rerun: got period=%0d ones=%0d required 1 8", period, ones_sum); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 20; it++) begin
      stim_q.delete();
      for (int i = 0; i < 40; i++) stim_q.push_back(8'($urandom_range(0, 5)));
      stim_q.push_back(stim_q[0]);
      model(); junk_val = 8'($urandom);
      run_meter(2, 1'($urandom), 1'($urandom));
      n_checks++; if (got_done !== 1'b1 || consumed != exp_used) begin n_fail++; $display("FAIL b2b_samples[%0d]: got done=%b used=%0d required 1 %0d", it, got_done, consumed, exp_used); end
      n_checks++; if (period !== 9'(exp_period)) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d required %0d", it, period, exp_period); end
      n_checks++; if (ones_sum !== 12'(exp_ones)) begin n_fail++; $display("FAIL b2b_ones[%0d]: got %0d required %0d", it, ones_sum, exp_ones); end
      n_checks++; if (lockup !== exp_lock || timeout !== exp_to) begin n_fail++; $display("FAIL b2b_flags[%0d]: got lockup=%b timeout=%b required %b %b", it, lockup, timeout, exp_lock, exp_to); end
      n_checks++; if (busy_after_start !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b/%b required 1/0", it, busy_after_start, busy); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b1 || period !== 9'(exp_period)) begin n_fail++; $display("FAIL b2b_hold[%0d]: got done=%b period=%0d required 1 %0d", it, done, period, exp_period); end
    end
  endtask

  initial begin
    test_reset();
    test_max_lfsr();
    test_constant();
    test_lockup();
    test_timeout();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
